maf_unpack: RTL and testbench
=============================

Name: maf_unpack

Overview:
- Inverse of the result-packing stage: takes a packed IEEE word (FP32, or two FP16 halves) plus the mode code `cont`. Returns sign, unbiased exponent, mantissa with hidden bit, and per-lane class flags.
- Sits at the operand-input side of the multiply-add datapath, feeding `E`/`M`-format operands.
- Two-stage valid/ready pipeline with full backpressure.
- Saturating counter of words received with an unsupported mode.

Parameters:
- CNT_W, 8, width of the unsupported-mode counter.
- BIAS32, 127, FP32 exponent bias.
- BIAS16, 15, FP16 exponent bias.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_word  in  32  packed operand word
- in_cont  in  3  mode: 000/010 = FP32, 001 = dual FP16, other = unsupported
- out_valid  out  1  decoded result valid
- out_ready  in  1  consumer accepts result
- s_out  out  1  FP32 sign, or low FP16 lane sign (bit 15)
- sh_out  out  1  high FP16 lane sign (bit 31); 0 in FP32 mode
- e_out  out  12  unbiased exponent(s), two's complement, layout below
- m_out  out  24  mantissa(s) with hidden bit, layout below
- cont_out  out  3  mode carried with the data
- is_zero  out  2  [0] = FP32 or low lane, [1] = high lane
- is_sub  out  2  subnormal flags, same lane mapping
- is_inf  out  2  infinity flags, same lane mapping
- is_nan  out  2  NaN flags, same lane mapping
- bad_cnt  out  CNT_W  saturating count of accepted unsupported-mode words

Behaviour:
- Reset: all outputs 0, both stage valids 0, bad_cnt 0.
- Reset is asynchronous; asserting it mid-operation discards in-flight words with no output.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready, purely combinational, with no in_valid→in_ready path.
- Pipeline:
  - Stage 1 registers in_word and in_cont.
  - Stage 2 decodes and registers all outputs.
  - Each stage loads when its successor is empty or advancing.
  - Latency 2 cycles when not stalled; throughput 1 word/clk.
  - While out_valid && !out_ready, all outputs are held stable.
- FP32 mode:
  - s_out = w[31]; sh_out = 0.
  - If the exponent field f = w[30:23] is nonzero: e_out[7:0] = f − 127 (8-bit wrap).
  - If f = 0: e_out[7:0] = −126 (0x82).
  - e_out[11:8] = sign extension of e_out[7].
  - m_out = {f≠0, w[22:0]}.
  - Classes, reported on lane 0 (bit 0 of each flag):
    - zero: f = 0 and frac = 0
    - sub: f = 0 and frac ≠ 0
    - inf: f = 0xFF and frac = 0
    - nan: f = 0xFF and frac ≠ 0
  - For f = 0xFF: e_out[7:0] = 0x80.
  - Flag bit 1 = 0.
- Dual FP16 mode:
  - High lane = w[31:16]; sh_out = w[31]; e_out[10:6] = f_hi − 15 (5-bit wrap).
  - Low lane = w[15:0]; s_out = w[15]; e_out[5:0] = sign-extended 6-bit (f_lo − 15).
  - e_out[11] = e_out[10].
  - f = 0 maps to exponent −14; f = 0x1F maps to 0x10 (5-bit).
  - m_out[22] = f_hi≠0; m_out[21:12] = hi frac; m_out[10] = f_lo≠0; m_out[9:0] = lo frac.
  - m_out[23] = 0 and m_out[11] = 0.
  - Per-lane class flags use the same rules as FP32 with a 5-bit exponent.
- Unsupported mode:
  - All data outputs and flags are 0; cont_out still carries the mode.
  - The word still flows through the pipeline and is handshaked normally.
  - bad_cnt increments by 1 when the word is accepted into stage 1, saturating at 2^CNT_W−1.
- cont_out always equals the mode that arrived with the data.

Decomposition:
- Shared package `maf_pkg`:
  - Mode constants MODE_FP32 = 3'b000, MODE_F16X2 = 3'b001, MODE_FP32B = 3'b010.
  - BIAS32, BIAS16.
  - Field-position constants for FP32 and FP16.
  - Struct `fp_class_t` {zero, sub, inf, nan}.
- Sub-module `maf_fp_classify`: combinational classifier, parameterised by exponent width (8 or 5). Three instances: one FP32, two FP16.

Test Plan:
- Basic FP32: reset, then in_word 0x3F800000, cont 000 → two cycles later s_out 0, e_out 0x000, m_out 0x800000, all flags 0.
- Dual FP16: in_word 0xC0003C00, cont 001 → sh_out 1, s_out 0, e_out[10:6] = 1, e_out[5:0] = 0, m_out 0x400400, flags 0.
- Special values:
  - FP32 0x7FC00000 → is_nan 01, e_out[7:0] 0x80.
  - FP32 0x00000001 → is_sub 01, e_out 0xF82, m_out 0x000001.
  - FP16x2 0x7C000000 → is_inf 10, is_zero 01.
- Backpressure: out_ready low, issue 3 back-to-back words → first 2 accepted, in_ready falls, outputs hold word 1. out_ready high → words 1, 2, 3 in order, none lost or duplicated.
- Unsupported mode: 300 accepted words with cont 011 → all data outputs 0, cont_out 011, bad_cnt saturates at 255.
- Reset mid-operation: rstn low while both stages are valid → out_valid 0 immediately. After release: no stale output, bad_cnt 0.

Source files
------------

// File: rtl/maf_pkg.sv
// Shared constants and types for the multiply-add operand unpack stage:
// mode codes, exponent biases, IEEE field positions and class/output records.
package maf_pkg;

    localparam logic [2:0] MODE_FP32  = 3'b000;
    localparam logic [2:0] MODE_F16X2 = 3'b001;
    localparam logic [2:0] MODE_FP32B = 3'b010;

    localparam int BIAS32 = 127;
    localparam int BIAS16 = 15;

    localparam int F32_SIGN    = 31;
    localparam int F32_EXP_LSB = 23;
    localparam int F32_EXP_W   = 8;
    localparam int F32_FRAC_W  = 23;

    localparam int F16_SIGN    = 15;
    localparam int F16_EXP_LSB = 10;
    localparam int F16_EXP_W   = 5;
    localparam int F16_FRAC_W  = 10;
    localparam int F16_HI_LSB  = 16;

    typedef struct packed {
        logic zero;
        logic sub;
        logic inf;
        logic nan;
    } fp_class_t;

    typedef enum logic [1:0] {
        FMT_FP32,
        FMT_F16X2,
        FMT_BAD
    } fmt_e;

    typedef struct packed {
        logic        s;
        logic        sh;
        logic [11:0] e;
        logic [23:0] m;
        logic [2:0]  cont;
        logic [1:0]  is_zero;
        logic [1:0]  is_sub;
        logic [1:0]  is_inf;
        logic [1:0]  is_nan;
    } unpack_out_t;

    // Both FP32 encodings decode identically; anything else is unsupported.
    function automatic fmt_e mode_fmt(input logic [2:0] cont);
        case (cont)
            MODE_FP32, MODE_FP32B: return FMT_FP32;
            MODE_F16X2:            return FMT_F16X2;
            default:               return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/maf_unpack_if.sv
// Operand-in / decoded-out handshake bundle of the unpack stage.
// slave = the unpack block, master = whoever feeds and drains it.
interface maf_unpack_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic [2:0]  in_cont;

    logic        out_valid;
    logic        out_ready;
    logic        s_out;
    logic        sh_out;
    logic [11:0] e_out;
    logic [23:0] m_out;
    logic [2:0]  cont_out;
    logic [1:0]  is_zero;
    logic [1:0]  is_sub;
    logic [1:0]  is_inf;
    logic [1:0]  is_nan;

    modport slave (
        input  in_valid, in_word, in_cont, out_ready,
        output in_ready, out_valid, s_out, sh_out, e_out, m_out, cont_out,
               is_zero, is_sub, is_inf, is_nan
    );

    modport master (
        output in_valid, in_word, in_cont, out_ready,
        input  in_ready, out_valid, s_out, sh_out, e_out, m_out, cont_out,
               is_zero, is_sub, is_inf, is_nan
    );

endinterface

// File: rtl/maf_fp_classify.sv
// Combinational IEEE class decode for one lane, sized by exponent/fraction width.
module maf_fp_classify
    import maf_pkg::*;
#(
    parameter int EW = 8,
    parameter int FW = 23
) (
    input  logic [EW-1:0] exp_f,
    input  logic [FW-1:0] frac,
    output fp_class_t     cls
);

    logic exp_zero;
    logic exp_ones;
    logic frac_nz;

    // NOTE: every signal written here gets a value on every path, so no latch can be inferred.
    always_comb begin
        exp_zero = (exp_f == '0);
        exp_ones = &exp_f;
        frac_nz  = |frac;
        cls.zero = exp_zero && !frac_nz;
        cls.sub  = exp_zero &&  frac_nz;
        cls.inf  = exp_ones && !frac_nz;
        cls.nan  = exp_ones &&  frac_nz;
    end

endmodule

// File: rtl/maf_unpack.sv
// Two-stage valid/ready unpack of a packed FP32 or dual-FP16 operand word into
// sign, unbiased exponent, hidden-bit mantissa and per-lane class flags.
module maf_unpack #(
    parameter int CNT_W  = 8,
    parameter int BIAS32 = maf_pkg::BIAS32,
    parameter int BIAS16 = maf_pkg::BIAS16
) (
    input  logic             clk,
    input  logic             rstn,
    maf_unpack_if.slave      bus,
    output logic [CNT_W-1:0] bad_cnt
);

    import maf_pkg::*;

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_word_q,  s1_word_d;
    logic [2:0]       s1_cont_q,  s1_cont_d;
    logic             s2_valid_q, s2_valid_d;
    unpack_out_t      out_q,      out_d;
    logic [CNT_W-1:0] bad_cnt_q,  bad_cnt_d;

    logic s1_en, s2_en, in_fire, in_bad;

    // A stage loads when the one after it is empty or draining this cycle.
    assign s2_en        = !s2_valid_q || bus.out_ready;
    assign s1_en        = !s1_valid_q || s2_en;
    assign bus.in_ready = s1_en;
    assign in_fire      = bus.in_valid && s1_en;
    assign in_bad       = (mode_fmt(bus.in_cont) == FMT_BAD);

    fp_class_t c32, chi, clo;

    maf_fp_classify #(.EW(F32_EXP_W), .FW(F32_FRAC_W)) u_cls32 (
        .exp_f (s1_word_q[F32_EXP_LSB +: F32_EXP_W]),
        .frac  (s1_word_q[0 +: F32_FRAC_W]),
        .cls   (c32)
    );

    maf_fp_classify #(.EW(F16_EXP_W), .FW(F16_FRAC_W)) u_cls_hi (
        .exp_f (s1_word_q[F16_HI_LSB + F16_EXP_LSB +: F16_EXP_W]),
        .frac  (s1_word_q[F16_HI_LSB +: F16_FRAC_W]),
        .cls   (chi)
    );

    maf_fp_classify #(.EW(F16_EXP_W), .FW(F16_FRAC_W)) u_cls_lo (
        .exp_f (s1_word_q[F16_EXP_LSB +: F16_EXP_W]),
        .frac  (s1_word_q[0 +: F16_FRAC_W]),
        .cls   (clo)
    );

    logic [7:0]  f32, e32;
    logic [4:0]  fh, fl, eh;
    logic [5:0]  el;
    unpack_out_t dec;

    // Exponent field 0 decodes as the minimum normal exponent (subnormal scale).
    always_comb begin
        f32 = s1_word_q[F32_EXP_LSB +: F32_EXP_W];
        fh  = s1_word_q[F16_HI_LSB + F16_EXP_LSB +: F16_EXP_W];
        fl  = s1_word_q[F16_EXP_LSB +: F16_EXP_W];
        e32 = (f32 == '0) ? 8'(1 - BIAS32) : f32 - 8'(BIAS32);
        eh  = (fh  == '0) ? 5'(1 - BIAS16) : fh - 5'(BIAS16);
        el  = (fl  == '0) ? 6'(1 - BIAS16) : {1'b0, fl} - 6'(BIAS16);

        dec      = '0;
        dec.cont = s1_cont_q;
        case (mode_fmt(s1_cont_q))
            FMT_FP32: begin
                dec.s       = s1_word_q[F32_SIGN];
                dec.e       = {{4{e32[7]}}, e32};
                dec.m       = {(f32 != '0), s1_word_q[0 +: F32_FRAC_W]};
                dec.is_zero = {1'b0, c32.zero};
                dec.is_sub  = {1'b0, c32.sub};
                dec.is_inf  = {1'b0, c32.inf};
                dec.is_nan  = {1'b0, c32.nan};
            end
            FMT_F16X2: begin
                dec.s       = s1_word_q[F16_SIGN];
                dec.sh      = s1_word_q[F16_HI_LSB + F16_SIGN];
                dec.e       = {eh[4], eh, el};
                dec.m       = {1'b0, (fh != '0), s1_word_q[F16_HI_LSB +: F16_FRAC_W],
                               1'b0, (fl != '0), s1_word_q[0 +: F16_FRAC_W]};
                dec.is_zero = {chi.zero, clo.zero};
                dec.is_sub  = {chi.sub,  clo.sub};
                dec.is_inf  = {chi.inf,  clo.inf};
                dec.is_nan  = {chi.nan,  clo.nan};
            end
            default: ;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_en ? bus.in_valid : s1_valid_q;
        s1_word_d  = s1_word_q;
        s1_cont_d  = s1_cont_q;
        if (in_fire) begin
            s1_word_d = bus.in_word;
            s1_cont_d = bus.in_cont;
        end

        s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
        out_d      = (s2_en && s1_valid_q) ? dec : out_q;

        bad_cnt_d = bad_cnt_q;
        if (in_fire && in_bad && (bad_cnt_q != '1)) begin
            bad_cnt_d = bad_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
            s1_cont_q  <= '0;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            bad_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_word_q  <= s1_word_d;
            s1_cont_q  <= s1_cont_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.s_out     = out_q.s;
    assign bus.sh_out    = out_q.sh;
    assign bus.e_out     = out_q.e;
    assign bus.m_out     = out_q.m;
    assign bus.cont_out  = out_q.cont;
    assign bus.is_zero   = out_q.is_zero;
    assign bus.is_sub    = out_q.is_sub;
    assign bus.is_inf    = out_q.is_inf;
    assign bus.is_nan    = out_q.is_nan;
    assign bad_cnt       = bad_cnt_q;

endmodule

// File: tb/tb_maf_unpack.sv
// Directed bench for maf_unpack: hand-computed decode vectors, backpressure,
// unsupported-mode counting with saturation, and asynchronous mid-flight reset.
module tb_maf_unpack;

    localparam int CNT_W = 8;

    logic             clk  = 1'b0;
    logic             rstn = 1'b0;
    logic [CNT_W-1:0] bad_cnt;
    int               n_checks = 0;
    int               n_fail   = 0;

    maf_unpack_if bus ();

    maf_unpack #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .bad_cnt (bad_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic s, input logic sh,
                              input logic [11:0] e, input logic [23:0] m, input logic [2:0] cont,
                              input logic [1:0] z, input logic [1:0] sb,
                              input logic [1:0] inf, input logic [1:0] nan);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".s"},     32'(bus.s_out),     32'(s));
        check({tag, ".sh"},    32'(bus.sh_out),    32'(sh));
        check({tag, ".e"},     32'(bus.e_out),     32'(e));
        check({tag, ".m"},     32'(bus.m_out),     32'(m));
        check({tag, ".cont"},  32'(bus.cont_out),  32'(cont));
        check({tag, ".zero"},  32'(bus.is_zero),   32'(z));
        check({tag, ".sub"},   32'(bus.is_sub),    32'(sb));
        check({tag, ".inf"},   32'(bus.is_inf),    32'(inf));
        check({tag, ".nan"},   32'(bus.is_nan),    32'(nan));
    endtask

    // One word through an empty pipeline with the consumer ready: checks the
    // two-cycle latency, then the decoded fields.
    task automatic send_one(input string tag, input logic [31:0] word, input logic [2:0] cont,
                            input logic s, input logic sh, input logic [11:0] e,
                            input logic [23:0] m, input logic [1:0] z, input logic [1:0] sb,
                            input logic [1:0] inf, input logic [1:0] nan);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_word   = word;
        bus.in_cont   = cont;
        bus.out_ready = 1'b1;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, ".lat1"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        expect_out(tag, s, sh, e, m, cont, z, sb, inf, nan);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.in_cont   = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.e",         32'(bus.e_out),     32'd0);
        check("rst.m",         32'(bus.m_out),     32'd0);
        check("rst.s",         32'(bus.s_out),     32'd0);
        check("rst.cont",      32'(bus.cont_out),  32'd0);
        check("rst.flags",     32'({bus.is_zero, bus.is_sub, bus.is_inf, bus.is_nan}), 32'd0);
        check("rst.in_ready",  32'(bus.in_ready),  32'd1);
        check("rst.bad_cnt",   32'(bad_cnt),       32'd0);
        rstn = 1'b1;

        // Decode vectors: tag, word, cont, s, sh, e, m, zero, sub, inf, nan
        send_one("fp32_one",   32'h3F800000, 3'b000, 1'b0, 1'b0, 12'h000, 24'h800000, 2'b00, 2'b00, 2'b00, 2'b00);
        send_one("f16_pair",   32'hC0003C00, 3'b001, 1'b0, 1'b1, 12'h040, 24'h400400, 2'b00, 2'b00, 2'b00, 2'b00);
        send_one("fp32_nan",   32'h7FC00000, 3'b000, 1'b0, 1'b0, 12'hF80, 24'hC00000, 2'b00, 2'b00, 2'b00, 2'b01);
        send_one("fp32_sub",   32'h00000001, 3'b000, 1'b0, 1'b0, 12'hF82, 24'h000001, 2'b00, 2'b01, 2'b00, 2'b00);
        send_one("f16_infzero",32'h7C000000, 3'b001, 1'b0, 1'b0, 12'hC32, 24'h400000, 2'b01, 2'b00, 2'b10, 2'b00);
        send_one("fp32b_negpi",32'hC0490FDB, 3'b010, 1'b1, 1'b0, 12'h001, 24'hC90FDB, 2'b00, 2'b00, 2'b00, 2'b00);
        send_one("f16_subs",   32'h83FF0001, 3'b001, 1'b0, 1'b1, 12'hCB2, 24'h3FF001, 2'b00, 2'b11, 2'b00, 2'b00);
        send_one("fp32_ninf",  32'hFF800000, 3'b000, 1'b1, 1'b0, 12'hF80, 24'h800000, 2'b00, 2'b00, 2'b01, 2'b00);
        send_one("fp32_zero",  32'h80000000, 3'b000, 1'b1, 1'b0, 12'hF82, 24'h000000, 2'b01, 2'b00, 2'b00, 2'b00);
        check("supported.bad_cnt", 32'(bad_cnt), 32'd0);

        // Backpressure: three back-to-back words against a stalled consumer.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_word   = 32'h3F800000;
        bus.in_cont   = 3'b000;
        check("bp.w1_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_word = 32'h40000000;
        check("bp.w2_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_word = 32'hBF800000;
        check("bp.w3_stall", 32'(bus.in_ready), 32'd0);
        expect_out("bp.hold0", 1'b0, 1'b0, 12'h000, 24'h800000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (2) @(negedge clk);
        check("bp.still_stall", 32'(bus.in_ready), 32'd0);
        expect_out("bp.hold2", 1'b0, 1'b0, 12'h000, 24'h800000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        expect_out("bp.w2", 1'b0, 1'b0, 12'h001, 24'h800000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        expect_out("bp.w3", 1'b1, 1'b0, 12'h000, 24'h800000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        check("bp.drained", 32'(bus.out_valid), 32'd0);

        // Unsupported mode: 300 streamed words, counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_word  = 32'hFFFFFFFF ^ 32'(i);
            bus.in_cont  = 3'b011;
            if (i == 10) begin
                check("bad.cnt10", 32'(bad_cnt), 32'd10);
                expect_out("bad.data", 1'b0, 1'b0, 12'h000, 24'h000000, 3'b011, 2'b00, 2'b00, 2'b00, 2'b00);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bad.saturated", 32'(bad_cnt), 32'd255);
        repeat (2) @(negedge clk);
        check("bad.drained", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset with both stages holding words.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_word   = 32'h12345678;
        bus.in_cont   = 3'b111;
        @(negedge clk);
        bus.in_word = 32'h3F800000;
        bus.in_cont = 3'b000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rstmid.full",  32'(bus.in_ready), 32'd0);
        check("rstmid.cont",  32'(bus.cont_out), 32'd7);
        #2 rstn = 1'b0;
        #1;
        check("rstmid.out_valid", 32'(bus.out_valid), 32'd0);
        check("rstmid.bad_cnt",   32'(bad_cnt),        32'd0);
        check("rstmid.cont0",     32'(bus.cont_out),   32'd0);
        @(negedge clk);
        rstn          = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rstpost.out_valid", 32'(bus.out_valid), 32'd0);
        check("rstpost.bad_cnt",   32'(bad_cnt),        32'd0);

        send_one("recover", 32'h40000000, 3'b000, 1'b0, 1'b0, 12'h001, 24'h800000, 2'b00, 2'b00, 2'b00, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
